// File: rtl/ft_regfile_pkg.sv
// Shared definitions for the fault-tolerant register file: copy-engine state
// encoding and the per-word parity helper used when FT_REGFILE_PARITY_EN is defined.
package ft_regfile_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CKPT = 2'd1;
    localparam logic [1:0] ST_ROLL = 2'd2;

    // Widest word the parity helper accepts; narrower words are zero-extended.
    localparam int PAR_MAX_W = 128;

    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ft_regfile_copy_fsm.sv
// Checkpoint/rollback sequencer: walks idx 1..NREGS-1 one word per cycle and
// owns the busy/done/valid/drop status flags.
module ft_regfile_copy_fsm
    import ft_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ckpt_req_i,
    input  logic                  rollback_req_i,
    input  logic                  we_a_i,
    output logic                  ckpt_en_o,
    output logic                  roll_en_o,
    output logic [ADDR_WIDTH-1:0] idx_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ckpt_valid_o,
    output logic                  wr_drop_o
);

    logic [1:0]            state_q;
    logic [ADDR_WIDTH-1:0] idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            ckpt_valid_o <= 1'b0;
            wr_drop_o    <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            wr_drop_o <= we_a_i && busy_o;
            case (state_q)
                ST_IDLE: begin
                    // Rollback has priority; without a valid snapshot it is dropped.
                    if (rollback_req_i && ckpt_valid_o) begin
                        state_q <= ST_ROLL;
                        idx_q   <= ADDR_WIDTH'(1);
                        busy_o  <= 1'b1;
                    end else if (ckpt_req_i) begin
                        state_q <= ST_CKPT;
                        idx_q   <= ADDR_WIDTH'(1);
                        busy_o  <= 1'b1;
                    end
                end
                ST_CKPT, ST_ROLL: begin
                    if (&idx_q) begin
                        state_q <= ST_IDLE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        if (state_q == ST_CKPT) ckpt_valid_o <= 1'b1;
                    end else begin
                        idx_q <= idx_q + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    assign ckpt_en_o = (state_q == ST_CKPT);
    assign roll_en_o = (state_q == ST_ROLL);
    assign idx_o     = idx_q;

endmodule

// File: rtl/ft_regfile.sv
// Register file with N combinational read ports, one write port, a shadow
// checkpoint array and sequential rollback. Optional parity: FT_REGFILE_PARITY_EN.
module ft_regfile
    import ft_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           test_en_i,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_READ-1:0]            perr_o,
    input  logic [ADDR_WIDTH-1:0]          waddr_a_i,
    input  logic [DATA_WIDTH-1:0]          wdata_a_i,
    input  logic                           we_a_i,
    input  logic                           ckpt_req_i,
    input  logic                           rollback_req_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           ckpt_valid_o,
    output logic                           wr_drop_o
);

    localparam int NREGS = 2**ADDR_WIDTH;
`ifdef FT_REGFILE_PARITY_EN
    localparam int WORD_W = DATA_WIDTH + 1;
`else
    localparam int WORD_W = DATA_WIDTH;
`endif

    logic [WORD_W-1:0]     live_q   [1:NREGS-1];
    logic [WORD_W-1:0]     shadow_q [1:NREGS-1];
    logic [WORD_W-1:0]     wword;
    logic                  ckpt_en, roll_en;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  unused_test_en;

    assign unused_test_en = test_en_i;

`ifdef FT_REGFILE_PARITY_EN
    assign wword = {even_parity(PAR_MAX_W'(wdata_a_i)), wdata_a_i};
`else
    assign wword = wdata_a_i;
`endif

    ft_regfile_copy_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_copy_fsm (
        .clk            (clk),
        .rst_n          (rst_n),
        .ckpt_req_i     (ckpt_req_i),
        .rollback_req_i (rollback_req_i),
        .we_a_i         (we_a_i),
        .ckpt_en_o      (ckpt_en),
        .roll_en_o      (roll_en),
        .idx_o          (idx),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .ckpt_valid_o   (ckpt_valid_o),
        .wr_drop_o      (wr_drop_o)
    );

    // Port writes are blocked while busy, so the rollback copy owns live_q then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) live_q[i] <= '0;
        end else if (roll_en) begin
            live_q[idx] <= shadow_q[idx];
        end else if (we_a_i && !busy_o && (waddr_a_i != '0)) begin
            live_q[waddr_a_i] <= wword;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) shadow_q[i] <= '0;
        end else if (ckpt_en) begin
            shadow_q[idx] <= live_q[idx];
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [WORD_W-1:0]     word;
        assign ra   = raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign word = (ra == '0) ? '0 : live_q[ra];
        assign rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = word[DATA_WIDTH-1:0];
`ifdef FT_REGFILE_PARITY_EN
        assign perr_o[p] = ^word;
`else
        assign perr_o[p] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ft_regfile.sv
// Directed self-checking bench for ft_regfile at default parameters.
module tb_ft_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        test_en_i = 1'b0;
    logic [9:0]  raddr_i = '0;
    logic [63:0] rdata_o;
    logic [1:0]  perr_o;
    logic [4:0]  waddr_a_i = '0;
    logic [31:0] wdata_a_i = '0;
    logic        we_a_i = 1'b0;
    logic        ckpt_req_i = 1'b0;
    logic        rollback_req_i = 1'b0;
    logic        busy_o, done_o, ckpt_valid_o, wr_drop_o;

    int checks = 0;
    int errors = 0;

    ft_regfile dut (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en_i),
        .raddr_i(raddr_i), .rdata_o(rdata_o), .perr_o(perr_o),
        .waddr_a_i(waddr_a_i), .wdata_a_i(wdata_a_i), .we_a_i(we_a_i),
        .ckpt_req_i(ckpt_req_i), .rollback_req_i(rollback_req_i),
        .busy_o(busy_o), .done_o(done_o), .ckpt_valid_o(ckpt_valid_o),
        .wr_drop_o(wr_drop_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we_a_i = 1'b1; waddr_a_i = a; wdata_a_i = d;
        step();
        we_a_i = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr_i = {a1, a0};
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done_o); end
        checks++; if (ckpt_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ckpt_valid_o); end
        checks++; if (wr_drop_o !== 1'b0) begin errors++; $display("FAIL reset_drop got %0b want 0", wr_drop_o); end
        rd(5'd1, 5'd31);
        checks++; if (rdata_o !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", rdata_o); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
        for (int i = 1; i < 32; i++) begin
            rd(5'(i), 5'(i));
            checks++;
            if (rdata_o !== {32'(i), 32'(i)}) begin
                errors++; $display("FAIL wr_rd reg%0d got %h want both %0d", i, rdata_o, i);
            end
        end
        wr(5'd0, 32'd100);
        rd(5'd0, 5'd0);
        checks++; if (rdata_o !== 64'h0) begin errors++; $display("FAIL reg0 got %h want 0", rdata_o); end
    endtask

    task automatic test_rollback_no_ckpt();
        int seen_busy = 0, seen_done = 0;
        rollback_req_i = 1'b1;
        step();
        rollback_req_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (busy_o) seen_busy++;
            if (done_o) seen_done++;
            step();
        end
        checks++; if (seen_busy != 0) begin errors++; $display("FAIL noroll_busy got %0d want 0", seen_busy); end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL noroll_done got %0d want 0", seen_done); end
        rd(5'd3, 5'd30);
        checks++; if (rdata_o !== {32'd30, 32'd3}) begin errors++; $display("FAIL noroll_data got %h want 30/3", rdata_o); end
    endtask

    task automatic test_ckpt();
        int cnt = 0, n = 0;
        ckpt_req_i = 1'b1;
        step();
        ckpt_req_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ckpt_busy_start got %0b want 1", busy_o); end
        if (busy_o) cnt++;
        wr(5'd5, 32'd77);
        checks++; if (wr_drop_o !== 1'b1) begin errors++; $display("FAIL ckpt_drop got %0b want 1", wr_drop_o); end
        if (busy_o) cnt++;
        while (busy_o && n < 100) begin
            step(); n++;
            if (busy_o) cnt++;
        end
        checks++; if (cnt != 31) begin errors++; $display("FAIL ckpt_busy_cycles got %0d want 31", cnt); end
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL ckpt_done got %0b want 1", done_o); end
        checks++; if (ckpt_valid_o !== 1'b1) begin errors++; $display("FAIL ckpt_valid got %0b want 1", ckpt_valid_o); end
        rd(5'd5, 5'd6);
        checks++; if (rdata_o !== {32'd6, 32'd5}) begin errors++; $display("FAIL ckpt_reg5 got %h want 6/5", rdata_o); end
        step();
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL ckpt_done_pulse got %0b want 0", done_o); end
    endtask

    task automatic test_rollback();
        int n = 0;
        for (int i = 1; i < 32; i++) wr(5'(i), 32'hFFFF_0000 + 32'(i));
        rd(5'd9, 5'd31);
        checks++; if (rdata_o !== {32'hFFFF_001F, 32'hFFFF_0009}) begin errors++; $display("FAIL ovw got %h", rdata_o); end
        rollback_req_i = 1'b1;
        step();
        rollback_req_i = 1'b0;
        while (!done_o && n < 100) begin step(); n++; end
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL roll_done got %0b want 1 after %0d", done_o, n); end
        for (int i = 1; i < 32; i++) begin
            rd(5'(i), 5'(32 - i));
            checks++;
            if (rdata_o !== {32'(32 - i), 32'(i)}) begin
                errors++; $display("FAIL roll_reg%0d got %h want %0d/%0d", i, rdata_o, 32 - i, i);
            end
        end
    endtask

    task automatic test_write_with_ckpt();
        int n = 0;
        we_a_i = 1'b1; waddr_a_i = 5'd5; wdata_a_i = 32'd77; ckpt_req_i = 1'b1;
        step();
        we_a_i = 1'b0; ckpt_req_i = 1'b0;
        while (!done_o && n < 100) begin step(); n++; end
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL wck_done got %0b want 1", done_o); end
        wr(5'd5, 32'd0);
        rollback_req_i = 1'b1;
        step();
        rollback_req_i = 1'b0;
        n = 0;
        while (!done_o && n < 100) begin step(); n++; end
        rd(5'd5, 5'd6);
        checks++; if (rdata_o !== {32'd6, 32'd77}) begin errors++; $display("FAIL wck_reg5 got %h want 6/77", rdata_o); end
    endtask

    task automatic test_both_req();
        int n = 0;
        wr(5'd6, 32'hAA);
        rollback_req_i = 1'b1; ckpt_req_i = 1'b1;
        step();
        rollback_req_i = 1'b0; ckpt_req_i = 1'b0;
        while (!done_o && n < 100) begin step(); n++; end
        rd(5'd6, 5'd6);
        checks++; if (rdata_o !== {32'd6, 32'd6}) begin errors++; $display("FAIL both_reg6 got %h want 6 (rollback)", rdata_o); end
    endtask

    task automatic test_reset_mid_copy();
        ckpt_req_i = 1'b1;
        step();
        ckpt_req_i = 1'b0;
        for (int c = 0; c < 9; c++) step();
        rst_n = 1'b0;
        #2;
        checks++; if ({busy_o, done_o, ckpt_valid_o, wr_drop_o} !== 4'b0) begin
            errors++; $display("FAIL midrst_flags got %b want 0000", {busy_o, done_o, ckpt_valid_o, wr_drop_o});
        end
        rd(5'd3, 5'd20);
        checks++; if (rdata_o !== 64'h0) begin errors++; $display("FAIL midrst_data got %h want 0", rdata_o); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        rollback_req_i = 1'b1;
        step();
        rollback_req_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_roll_busy got %0b want 0", busy_o); end
    endtask

    task automatic test_parity();
        wr(5'd7, 32'h1234_5677);
        wr(5'd3, 32'h0000_0003);
        rd(5'd7, 5'd3);
        checks++; if (perr_o !== 2'b00) begin errors++; $display("FAIL par_clean got %b want 00", perr_o); end
`ifdef FT_REGFILE_PARITY_EN
        begin
            logic [32:0] flip;
            flip = dut.live_q[7];
            flip[4] = ~flip[4];
            force dut.live_q[7] = flip;
            rd(5'd7, 5'd3);
            checks++; if (perr_o !== 2'b01) begin errors++; $display("FAIL par_flip got %b want 01", perr_o); end
            rd(5'd0, 5'd7);
            checks++; if (perr_o !== 2'b10) begin errors++; $display("FAIL par_flip_p1 got %b want 10", perr_o); end
            release dut.live_q[7];
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_rollback_no_ckpt();
        test_ckpt();
        test_rollback();
        test_write_with_ckpt();
        test_both_req();
        test_reset_mid_copy();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
